alu_multiword_seq: RTL and testbench
====================================

Name: alu_multiword_seq

Overview:
- Multi-cycle sequencer directly upstream of the 16-bit combinational ALU (ports A, B, F, Cin, Result, Status).
- Performs WORDS×16-bit operations by driving the ALU one 16-bit word per cycle and chaining the carry between words.
- Collects the per-word results into a wide result register and produces a wide-width status vector.
- Uses a valid/ready handshake on both its request side and its result side.

Parameters:
WORDS, 4, number of 16-bit words per operand (operand width W = 16*WORDS; legal range 2..8).

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  request valid
in_ready  output  1  request accepted when in_valid & in_ready
op  input  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT, 6 SHL (by 1), 7 SHR (logical, by 1)
opa  input  W  first operand
opb  input  W  second operand (ignored for NOT/SHL/SHR)
out_valid  output  1  result valid
out_ready  input  1  result consumed when out_valid & out_ready
res  output  W  wide result
flags  output  6  {CF, ZF, NF, VF, PF, AF}
alu_a  output  16  to ALU A
alu_b  output  16  to ALU B
alu_f  output  5  to ALU F
alu_cin  output  1  to ALU Cin
alu_result  input  16  from ALU Result
alu_status  input  6  from ALU Status {CF, ZF, NF, VF, PF, AF}

Behaviour:
- Reset state (rst_n low, asynchronous):
  - FSM goes to IDLE.
  - res = 0, flags = 0, out_valid = 0, in_ready = 1.
  - alu_a = alu_b = 0, alu_f = 0, alu_cin = 0.
  - Word counter and carry register = 0.
  - Reset mid-RUN or mid-DONE aborts the operation; no partial result is ever presented.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1, out_valid = 0, alu_f = 0.
  - On the handshake: latch op/opa/opb, clear carry, clear zero accumulator, set counter to the first word, then go to RUN.
- Word order:
  - SHR processes words from MSW down to word 0.
  - All other ops process word 0 up to the MSW.
- RUN (exactly WORDS cycles):
  - alu_a/alu_b = current word of the latched operands.
  - alu_cin = carry register.
  - At each clock edge, alu_result is written into the corresponding word of res, and the carry register updates.
  - After the last word, go to DONE.
  - in_ready = 0; in_valid is ignored.
- ALU opcode selection per op:
  - ADD: word 0 uses 00100, then 00101 (ADC).
  - SUB: word 0 uses 00110, then 00111 (SBB).
  - AND 01000, OR 01001, XOR 01010, NOT 01011.
  - SHL: 10110 (RCL) on all words.
  - SHR: 10111 (RCR) on all words.
- Carry register update:
  - ADD/SUB: alu_status CF (carry out / borrow out).
  - SHL: current opa word bit 15.
  - SHR: current opa word bit 0.
  - Logic ops: 0.
- Latency: handshake at edge N gives out_valid = 1 after edge N+WORDS+… specifically, out_valid is high in the cycle following edge N+WORDS.
- DONE:
  - out_valid = 1; res and flags are held stable until out_ready.
  - On the out handshake, go to IDLE.
  - A new request can be accepted one cycle later.
- Final flags (registered on the last RUN edge):
  - CF = final carry register (0 for logic ops).
  - ZF = 1 iff all W result bits are 0.
  - NF = res[W-1].
  - VF = alu_status VF of the MSW step for ADD/SUB, else 0.
  - PF = even parity of res[7:0] (1 when the count of ones is even).
  - AF = alu_status AF of the word-0 step for ADD/SUB, else 0.
- Arithmetic is modulo 2^W; no saturation.
- The sequencer relies on the ALU being purely combinational within the cycle.

Test Plan:
- ADD opa=0x0000_0000_0000_FFFF, opb=1 -> res=0x0000_0000_0001_0000; flags CF0 ZF0 NF0 VF0 PF1; out_valid rises exactly after the 4th RUN edge.
- ADD opa=0xFFFF_FFFF_FFFF_FFFF, opb=1 -> res=0; CF1 ZF1 NF0 VF0. Then ADD 0x7FFF_FFFF_FFFF_FFFF + 1 -> 0x8000_0000_0000_0000; VF1 NF1 CF0.
- SUB 0 - 1 -> res=0xFFFF_FFFF_FFFF_FFFF; CF1 NF1 ZF0 PF1. Then XOR with equal operands 0x1234_5678_9ABC_DEF0 -> res=0; ZF1 CF0.
- SHL 0x8000_0000_0000_8000 -> 0x0000_0000_0001_0000, CF1. SHR 0x0001_0000_0000_0001 -> 0x0000_8000_0000_0000, CF1; check alu_f=10111 and the MSW-first alu_a sequence.
- Backpressure: hold out_ready=0 for 3 cycles in DONE -> res/flags/out_valid stable. Pulsing in_valid during RUN/DONE is ignored (in_ready=0). Next request is accepted the cycle after the out handshake.
- Assert rst_n=0 asynchronously mid-RUN (after word 1) -> immediately out_valid=0, res=0, flags=0, in_ready=1. After release, a fresh ADD 2+3 yields res=5.

Source files
------------

// File: rtl/alu_multiword_seq.sv
// Multi-word sequencer: drives a 16-bit combinational ALU one word per cycle,
// chains the carry between words and assembles a wide result plus flags.
module alu_multiword_seq #(
   parameter int unsigned WORDS = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [2:0]            op,
   input  logic [16*WORDS-1:0]   opa,
   input  logic [16*WORDS-1:0]   opb,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [16*WORDS-1:0]   res,
   output logic [5:0]            flags,
   output logic [15:0]           alu_a,
   output logic [15:0]           alu_b,
   output logic [4:0]            alu_f,
   output logic                  alu_cin,
   input  logic [15:0]           alu_result,
   input  logic [5:0]            alu_status
);

   localparam int unsigned W  = 16 * WORDS;
   localparam int unsigned CW = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [CW-1:0] LAST_WORD = CW'(WORDS - 1);

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_AND = 3'd2;
   localparam logic [2:0] OP_OR  = 3'd3;
   localparam logic [2:0] OP_XOR = 3'd4;
   localparam logic [2:0] OP_NOT = 3'd5;
   localparam logic [2:0] OP_SHL = 3'd6;
   localparam logic [2:0] OP_SHR = 3'd7;

   localparam logic [4:0] F_ADD = 5'b00100;
   localparam logic [4:0] F_ADC = 5'b00101;
   localparam logic [4:0] F_SUB = 5'b00110;
   localparam logic [4:0] F_SBB = 5'b00111;
   localparam logic [4:0] F_AND = 5'b01000;
   localparam logic [4:0] F_OR  = 5'b01001;
   localparam logic [4:0] F_XOR = 5'b01010;
   localparam logic [4:0] F_NOT = 5'b01011;
   localparam logic [4:0] F_RCL = 5'b10110;
   localparam logic [4:0] F_RCR = 5'b10111;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t          state_q, state_nxt;
   logic [2:0]      op_q, op_nxt;
   logic [W-1:0]    opa_q, opa_nxt;
   logic [W-1:0]    opb_q, opb_nxt;
   logic [CW-1:0]   cnt_q, cnt_nxt;
   logic            carry_q, carry_nxt;
   logic            af_q, af_nxt;
   logic [W-1:0]    res_nxt;
   logic [5:0]      flags_nxt;
   logic [15:0]     alu_a_nxt, alu_b_nxt, cur_a;
   logic [4:0]      alu_f_nxt;
   logic            alu_cin_nxt, in_ready_nxt, out_valid_nxt;
   logic            is_arith, last_word;

   // ZF/NF/PF of the narrow ALU are recomputed over the full width instead
   logic            unused_status_c;
   assign unused_status_c = ^{alu_status[4], alu_status[3], alu_status[1]};

   // ALU function code for an op; ADD/SUB use the carry-chained form after word 0
   function automatic logic [4:0] alu_code(input logic [2:0] o, input logic first);
      case (o)
         OP_ADD:  return first ? F_ADD : F_ADC;
         OP_SUB:  return first ? F_SUB : F_SBB;
         OP_AND:  return F_AND;
         OP_OR:   return F_OR;
         OP_XOR:  return F_XOR;
         OP_NOT:  return F_NOT;
         OP_SHL:  return F_RCL;
         default: return F_RCR;
      endcase
   endfunction

   // 16-bit word i of a wide operand
   function automatic logic [15:0] word_of(input logic [W-1:0] v, input logic [CW-1:0] i);
      return v[{i, 4'b0000} +: 16];
   endfunction

   // Next-state, datapath and output logic
   always_comb begin
      state_nxt   = state_q;
      op_nxt      = op_q;
      opa_nxt     = opa_q;
      opb_nxt     = opb_q;
      cnt_nxt     = cnt_q;
      carry_nxt   = carry_q;
      af_nxt      = af_q;
      res_nxt     = res;
      flags_nxt   = flags;
      alu_a_nxt   = alu_a;
      alu_b_nxt   = alu_b;
      alu_f_nxt   = alu_f;
      alu_cin_nxt = alu_cin;
      is_arith    = (op_q == OP_ADD) || (op_q == OP_SUB);
      cur_a       = word_of(opa_q, cnt_q);
      last_word   = 1'b0;

      case (state_q)
         IDLE: begin
            alu_f_nxt = 5'b00000;
            if (in_valid) begin
               op_nxt      = op;
               opa_nxt     = opa;
               opb_nxt     = opb;
               cnt_nxt     = (op == OP_SHR) ? LAST_WORD : '0;
               carry_nxt   = 1'b0;
               af_nxt      = 1'b0;
               alu_a_nxt   = word_of(opa, cnt_nxt);
               alu_b_nxt   = word_of(opb, cnt_nxt);
               alu_f_nxt   = alu_code(op, 1'b1);
               alu_cin_nxt = 1'b0;
               state_nxt   = RUN;
            end
         end
         RUN: begin
            res_nxt[{cnt_q, 4'b0000} +: 16] = alu_result;
            case (op_q)
               OP_ADD, OP_SUB: carry_nxt = alu_status[5];
               OP_SHL:         carry_nxt = cur_a[15];
               OP_SHR:         carry_nxt = cur_a[0];
               default:        carry_nxt = 1'b0;
            endcase
            if (is_arith && (cnt_q == '0)) af_nxt = alu_status[0];
            last_word = (op_q == OP_SHR) ? (cnt_q == '0) : (cnt_q == LAST_WORD);
            if (last_word) begin
               flags_nxt   = {carry_nxt, ~|res_nxt, res_nxt[W-1],
                              is_arith & alu_status[2], ~^res_nxt[7:0], af_nxt};
               alu_a_nxt   = 16'h0000;
               alu_b_nxt   = 16'h0000;
               alu_f_nxt   = 5'b00000;
               alu_cin_nxt = 1'b0;
               state_nxt   = DONE;
            end else begin
               cnt_nxt     = (op_q == OP_SHR) ? cnt_q - CW'(1) : cnt_q + CW'(1);
               alu_a_nxt   = word_of(opa_q, cnt_nxt);
               alu_b_nxt   = word_of(opb_q, cnt_nxt);
               alu_f_nxt   = alu_code(op_q, 1'b0);
               alu_cin_nxt = carry_nxt;
            end
         end
         DONE: begin
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase

      in_ready_nxt  = (state_nxt == IDLE);
      out_valid_nxt = (state_nxt == DONE);
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         op_q      <= 3'd0;
         opa_q     <= '0;
         opb_q     <= '0;
         cnt_q     <= '0;
         carry_q   <= 1'b0;
         af_q      <= 1'b0;
         res       <= '0;
         flags     <= 6'd0;
         alu_a     <= 16'h0000;
         alu_b     <= 16'h0000;
         alu_f     <= 5'b00000;
         alu_cin   <= 1'b0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
      end else begin
         state_q   <= state_nxt;
         op_q      <= op_nxt;
         opa_q     <= opa_nxt;
         opb_q     <= opb_nxt;
         cnt_q     <= cnt_nxt;
         carry_q   <= carry_nxt;
         af_q      <= af_nxt;
         res       <= res_nxt;
         flags     <= flags_nxt;
         alu_a     <= alu_a_nxt;
         alu_b     <= alu_b_nxt;
         alu_f     <= alu_f_nxt;
         alu_cin   <= alu_cin_nxt;
         in_ready  <= in_ready_nxt;
         out_valid <= out_valid_nxt;
      end
   end

endmodule

// File: tb/tb_alu_multiword_seq.sv
// Bench for alu_multiword_seq: 16-bit ALU stub, wide reference model, scoreboard.
module tb_alu_multiword_seq;

   localparam int unsigned WORDS = 4;
   localparam int unsigned W     = 16 * WORDS;

   typedef struct packed {
      logic [W-1:0] res;
      logic [5:0]   flags;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [2:0]    op = 3'd0;
   logic [W-1:0]  opa = '0;
   logic [W-1:0]  opb = '0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [W-1:0]  res;
   logic [5:0]    flags;
   logic [15:0]   alu_a, alu_b, alu_result;
   logic [4:0]    alu_f;
   logic          alu_cin;
   logic [5:0]    alu_status;

   exp_t          exp_q[$];
   exp_t          mon_e;
   int            chk_cnt = 0;
   int            pass_cnt = 0;

   alu_multiword_seq #(.WORDS(WORDS)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .opa(opa), .opb(opb), .out_valid(out_valid), .out_ready(out_ready),
      .res(res), .flags(flags), .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f),
      .alu_cin(alu_cin), .alu_result(alu_result), .alu_status(alu_status)
   );

   always #5 clk = ~clk;

   // 16-bit combinational ALU stub for the opcodes the sequencer uses
   logic [16:0] stub_s;
   logic [15:0] stub_r;
   logic        stub_c, stub_cf, stub_vf, stub_af;
   always_comb begin
      stub_s = 17'd0; stub_r = 16'h0; stub_c = 1'b0;
      stub_cf = 1'b0; stub_vf = 1'b0; stub_af = 1'b0;
      case (alu_f)
         5'b00100, 5'b00101: begin
            stub_c  = alu_f[0] & alu_cin;
            stub_s  = {1'b0, alu_a} + {1'b0, alu_b} + 17'(stub_c);
            stub_r  = stub_s[15:0];
            stub_cf = stub_s[16];
            stub_vf = (alu_a[15] == alu_b[15]) && (stub_r[15] != alu_a[15]);
            stub_af = ({1'b0, alu_a[3:0]} + {1'b0, alu_b[3:0]} + 5'(stub_c)) > 5'd15;
         end
         5'b00110, 5'b00111: begin
            stub_c  = alu_f[0] & alu_cin;
            stub_s  = {1'b0, alu_a} - {1'b0, alu_b} - 17'(stub_c);
            stub_r  = stub_s[15:0];
            stub_cf = stub_s[16];
            stub_vf = (alu_a[15] != alu_b[15]) && (stub_r[15] != alu_a[15]);
            stub_af = {1'b0, alu_a[3:0]} < ({1'b0, alu_b[3:0]} + 5'(stub_c));
         end
         5'b01000: stub_r = alu_a & alu_b;
         5'b01001: stub_r = alu_a | alu_b;
         5'b01010: stub_r = alu_a ^ alu_b;
         5'b01011: stub_r = ~alu_a;
         5'b10110: begin stub_r = {alu_a[14:0], alu_cin}; stub_cf = alu_a[15]; end
         5'b10111: begin stub_r = {alu_cin, alu_a[15:1]}; stub_cf = alu_a[0]; end
         default: stub_r = 16'h0;
      endcase
   end
   assign alu_result = stub_r;
   assign alu_status = {stub_cf, stub_r == 16'h0, stub_r[15], stub_vf, ~^stub_r[7:0], stub_af};

   // Reference model: whole-width arithmetic, no word slicing
   function automatic exp_t ref_calc(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W:0]   s;
      logic [W-1:0] r;
      logic         cf, vf, af;
      exp_t         e;
      cf = 1'b0; vf = 1'b0; af = 1'b0; r = '0; s = '0;
      case (o)
         3'd0: begin
            s  = {1'b0, a} + {1'b0, b};
            r  = s[W-1:0];
            cf = s[W];
            vf = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
            af = (5'(a[3:0]) + 5'(b[3:0])) > 5'd15;
         end
         3'd1: begin
            r  = a - b;
            cf = (a < b);
            vf = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
            af = (a[3:0] < b[3:0]);
         end
         3'd2: r = a & b;
         3'd3: r = a | b;
         3'd4: r = a ^ b;
         3'd5: r = ~a;
         3'd6: begin r = a << 1; cf = a[W-1]; end
         default: begin r = a >> 1; cf = a[0]; end
      endcase
      e.res   = r;
      e.flags = {cf, r == '0, r[W-1], vf, ~^r[7:0], af};
      return e;
   endfunction

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
      chk_cnt++;
      if (act === expv) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", name, act, expv);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one request; the expectation is queued on the accepting edge
   task automatic send(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b, input exp_t e);
      int n = 0;
      while (!in_ready && n < 100) begin tick(); n++; end
      if (!in_ready) begin
         chk_cnt++;
         $display("FAIL send_timeout: in_ready stuck low got 0 expected 1");
      end
      in_valid = 1'b1; op = o; opa = a; opb = b;
      tick();
      exp_q.push_back(e);
      in_valid = 1'b0;
   endtask

   task automatic send_ref(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
      send(o, a, b, ref_calc(o, a, b));
   endtask

   // Wait for out_valid (bounded) and take the result
   task automatic wait_done();
      int n = 0;
      out_ready = 1'b1;
      while (!out_valid && n < 100) begin tick(); n++; end
      if (!out_valid) begin
         chk_cnt++;
         $display("FAIL done_timeout: out_valid got 0 expected 1");
      end
      tick();
   endtask

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 4))
         0:       return '0;
         1:       return '1;
         2:       return W'(1);
         default: return {$urandom(), $urandom()};
      endcase
   endfunction

   // Scoreboard monitor: compares every presented result against the queue head
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            chk_cnt++;
            $display("FAIL unexpected_result: got res %0h expected no result", res);
         end else begin
            mon_e = exp_q.pop_front();
            check("res", res, mon_e.res);
            check("flags", W'(flags), W'(mon_e.flags));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time got 200000 expected completion");
      $fatal(1);
   end

   initial begin
      exp_t e;
      logic [W-1:0] a;

      // Reset state
      #12;
      check("rst_out_valid", W'(out_valid), W'(0));
      check("rst_in_ready", W'(in_ready), W'(1));
      check("rst_res", res, '0);
      check("rst_flags", W'(flags), W'(0));
      check("rst_alu_f", W'(alu_f), W'(0));
      check("rst_alu_a", W'(alu_a), W'(0));
      @(negedge clk) rst_n = 1'b1;
      tick();

      // ADD with carry into word 1, plus latency
      send(3'd0, 64'h0000_0000_0000_FFFF, 64'h1, '{res: 64'h0000_0000_0001_0000, flags: 6'b000011});
      for (int k = 1; k <= int'(WORDS); k++) begin
         tick();
         check($sformatf("latency_k%0d", k), W'(out_valid), W'(k == int'(WORDS)));
      end
      tick();

      send(3'd0, '1, 64'h1, '{res: 64'h0, flags: 6'b110011});
      wait_done();
      send(3'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, '{res: 64'h8000_0000_0000_0000, flags: 6'b001111});
      wait_done();
      send(3'd1, 64'h0, 64'h1, '{res: 64'hFFFF_FFFF_FFFF_FFFF, flags: 6'b101011});
      wait_done();
      send(3'd4, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, '{res: 64'h0, flags: 6'b010010});
      wait_done();
      send(3'd6, 64'h8000_0000_0000_8000, 64'h0, '{res: 64'h0000_0000_0001_0000, flags: 6'b100010});
      wait_done();

      // SHR: MSW-first word order on alu_a, RCR code, in_valid ignored while busy
      a = 64'h0001_0000_0000_0001;
      send(3'd7, a, 64'hDEAD_BEEF_0000_1111, '{res: 64'h0000_8000_0000_0000, flags: 6'b100010});
      for (int k = 0; k < int'(WORDS); k++) begin
         check($sformatf("shr_alu_a_k%0d", k), W'(alu_a), W'(a[(int'(WORDS) - 1 - k) * 16 +: 16]));
         check($sformatf("shr_alu_f_k%0d", k), W'(alu_f), W'(5'b10111));
         check($sformatf("busy_in_ready_k%0d", k), W'(in_ready), W'(0));
         in_valid = 1'b1; op = 3'd0; opa = '1; opb = '1;
         tick();
      end
      in_valid = 1'b0;
      wait_done();

      // Backpressure in DONE
      out_ready = 1'b0;
      a = {$urandom(), $urandom()};
      e = ref_calc(3'd1, a, 64'h0123_4567_89AB_CDEF);
      send(3'd1, a, 64'h0123_4567_89AB_CDEF, e);
      for (int n = 0; n < 100 && !out_valid; n++) tick();
      for (int k = 0; k < 3; k++) begin
         check($sformatf("bp_out_valid_k%0d", k), W'(out_valid), W'(1));
         check($sformatf("bp_res_k%0d", k), res, e.res);
         check($sformatf("bp_flags_k%0d", k), W'(flags), W'(e.flags));
         check($sformatf("bp_in_ready_k%0d", k), W'(in_ready), W'(0));
         in_valid = 1'b1; op = 3'd5;
         tick();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      tick();
      check("post_handshake_in_ready", W'(in_ready), W'(1));
      send_ref(3'd3, 64'h00F0_00F0_00F0_00F0, 64'h0F00_0F00_0F00_0F00);
      check("next_accepted", W'(in_ready), W'(0));
      wait_done();

      // Asynchronous reset mid-RUN aborts the operation
      send_ref(3'd0, '1, '1);
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      check("abort_out_valid", W'(out_valid), W'(0));
      check("abort_res", res, '0);
      check("abort_flags", W'(flags), W'(0));
      check("abort_in_ready", W'(in_ready), W'(1));
      exp_q.delete();
      @(negedge clk) rst_n = 1'b1;
      tick();
      send(3'd0, 64'h2, 64'h3, '{res: 64'h5, flags: 6'b000010});
      wait_done();

      // Randomized traffic against the reference model
      for (int i = 0; i < 40; i++) begin
         logic [2:0] o;
         logic [W-1:0] ra, rb;
         o  = 3'($urandom_range(0, 7));
         ra = pick();
         rb = pick();
         send_ref(o, ra, rb);
         wait_done();
      end

      tick();
      tick();
      check("queue_drained", W'(exp_q.size()), W'(0));
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
